// File: rtl/fma_issue_buffer.sv
// fma_issue_buffer: FIFO-fed, settle-timed, valid/ready wrapper around a combinational FP32 FMA core (optional result flags via FMA_RESULT_FLAGS_EN)
module fma_issue_buffer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [31:0]              in_c,
  output logic [31:0]              fma_a,
  output logic [31:0]              fma_b,
  output logic [31:0]              fma_c,
  input  logic [31:0]              fma_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_d,
`ifdef FMA_RESULT_FLAGS_EN
  output logic [3:0]               out_flags,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, SETTLE_WAIT, HOLD} state_t;
  state_t        state;
  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [SW-1:0] cnt;
  logic          push, pop;
  assign in_ready = count < (AW + 1)'(DEPTH);
  assign push     = in_valid && in_ready;
  // Pop only from entries already registered, so a fresh push is never issued in its own cycle
  assign pop      = (count != '0) && (state == IDLE || (state == HOLD && out_ready));
  // Operand storage; contents need no reset because count gates every read
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_a, in_b, in_c};
  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  // Issue, settle and result handshake; operands change only on pop so the core never sees a mixed triple
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fma_a     <= '0;
      fma_b     <= '0;
      fma_c     <= '0;
      out_d     <= '0;
      out_valid <= 1'b0;
`ifdef FMA_RESULT_FLAGS_EN
      out_flags <= '0;
`endif
    end else begin
      if (pop) begin
        {fma_a, fma_b, fma_c} <= mem[rptr];
        cnt <= SW'(SETTLE - 1);
      end
      case (state)
        IDLE: if (pop) state <= SETTLE_WAIT;
        SETTLE_WAIT:
          if (cnt == '0) begin
            out_d     <= fma_d;
            out_valid <= 1'b1;
            state     <= HOLD;
`ifdef FMA_RESULT_FLAGS_EN
            out_flags <= {fma_d[30:23] == 8'hFF && fma_d[22:0] != '0,
                          fma_d[30:23] == 8'hFF && fma_d[22:0] == '0,
                          fma_d[30:0] == '0,
                          fma_d[30:23] == 8'h00 && fma_d[22:0] != '0};
`endif
          end else cnt <= cnt - 1'b1;
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= pop ? SETTLE_WAIT : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fma_issue_buffer.sv
// tb_fma_issue_buffer: directed checks of fma_issue_buffer with a table-driven stand-in for the FMA core
module tb_fma_issue_buffer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, in_c, fma_a, fma_b, fma_c, fma_d, out_d;
  logic [2:0]  count;
`ifdef FMA_RESULT_FLAGS_EN
  logic [3:0]  out_flags;
`endif
  int tests = 0;
  int fails = 0;
  logic [31:0] res [16];
  int          rt  [16];
  int          nres, peak;
  logic        ready_dropped;

  always #5 clk = ~clk;

  // Known IEEE results for the hand-worked vectors; any other triple yields an integer mix used as a tag
  function automatic logic [31:0] core(input logic [31:0] a, b, c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'h40A00000;
    if (a == 32'h7F800000 && b == 32'h00000000 && c == 32'h3F800000) return 32'h7FC00000;
    if (a == 32'h00000000 && b == 32'h3F800000 && c == 32'h80000000) return 32'h00000000;
    return a + b + c;
  endfunction

  function automatic logic [31:0] tag_d(input int k);
    return core(32'(k), 32'(k) << 8, 32'(k) << 16);
  endfunction

  assign fma_d = core(fma_a, fma_b, fma_c);

  fma_issue_buffer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_d(fma_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
`ifdef FMA_RESULT_FLAGS_EN
    .out_flags(out_flags),
`endif
    .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tag(input int k);
    in_a = 32'(k);
    in_b = 32'(k) << 8;
    in_c = 32'(k) << 16;
  endtask

  task automatic set_ops(input logic [31:0] a, b, c);
    in_a = a;
    in_b = b;
    in_c = c;
  endtask

  // Push one triple into an empty, idle block and follow it through issue, settle and handshake
  task automatic single_op(input string tag, input logic [31:0] a, b, c, exp_d);
    set_ops(a, b, c);
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check({tag, "_cnt_after_push"}, 32'(count), 32'd1);
    tick();
    check({tag, "_fma_a"}, fma_a, a);
    check({tag, "_fma_b"}, fma_b, b);
    check({tag, "_fma_c"}, fma_c, c);
    check({tag, "_valid_e1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid_e2"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid_e3"}, 32'(out_valid), 32'd1);
    check({tag, "_out_d"}, out_d, exp_d);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_tag(0);
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_d", out_d, 32'd0);
    check("rst_fma_a", fma_a, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FMA_RESULT_FLAGS_EN
    check("rst_flags", 32'(out_flags), 32'd0);
`endif

    // Single op
    single_op("single", 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000);
    tick();
    check("single_hold_valid", 32'(out_valid), 32'd1);
    check("single_hold_d", out_d, 32'h40A00000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_cleared", 32'(out_valid), 32'd0);
    check("single_operand_hold", fma_a, 32'h3F800000);
    tick();
    check("single_idle_count", 32'(count), 32'd0);

    // Back-to-back: four pushes with the sink always ready
    nres = 0; peak = 0; ready_dropped = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 4);
      set_tag(i + 1);
      if (i < 4 && !in_ready) ready_dropped = 1'b1;
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (out_valid && nres < 16) begin
        res[nres] = out_d;
        rt[nres] = i;
        nres++;
      end
    end
    in_valid = 1'b0;
    check("b2b_nres", 32'(nres), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_d%0d", i), res[i], tag_d(i + 1));
    check("b2b_first_latency", 32'(rt[0]), 32'd3);
    for (int i = 1; i < 4; i++) check($sformatf("b2b_spacing%0d", i), 32'(rt[i] - rt[i-1]), 32'd3);
    check("b2b_peak", 32'(peak), 32'd3);
    check("b2b_drained", 32'(count), 32'd0);
    check("b2b_in_ready_held", 32'(ready_dropped), 32'd0);

    // Full with back-pressure: six offered, four queued plus one issued
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      set_tag(11 + i);
      tick();
    end
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_d", out_d, tag_d(11));
    tick(); tick();
    check("full_count_stable", 32'(count), 32'd4);
    check("full_hold_d", out_d, tag_d(11));
    out_ready = 1'b1;
    nres = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid && nres < 16) begin
        res[nres] = out_d;
        nres++;
      end
      tick();
    end
    check("full_nres", 32'(nres), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("full_d%0d", i), res[i], tag_d(11 + i));
    check("full_drained", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2; pointers wrap through index 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_tag(21 + i);
      tick();
      if (i == 1) check("pp_count_push_pop_c1", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_d0", out_d, tag_d(21));
    check("pp_count_before", 32'(count), 32'd2);
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_tag(24);
    tick();
    in_valid = 1'b0;
    check("pp_count_after", 32'(count), 32'd2);
    check("pp_issued", fma_a, 32'd22);
    nres = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && nres < 16) begin
        res[nres] = out_d;
        nres++;
      end
      tick();
    end
    check("pp_nres", 32'(nres), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("pp_d%0d", i + 1), res[i], tag_d(22 + i));

    // Reset while in SETTLE_WAIT with three queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      set_tag(31 + i);
      tick();
    end
    out_ready = 1'b1;
    set_tag(35);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rstmid_count", 32'(count), 32'd3);
    check("rstmid_fma_a", fma_a, 32'd32);
    check("rstmid_valid_low", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_d", out_d, 32'd0);
    check("rstmid_count0", 32'(count), 32'd0);
    check("rstmid_fma_a0", fma_a, 32'd0);
    check("rstmid_fma_c0", fma_c, 32'd0);
    tick(); tick();
    check("rstmid_no_output", 32'(out_valid), 32'd0);
    single_op("after_rst", 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000);
    out_ready = 1'b1;
    tick();
    check("after_rst_cleared", 32'(out_valid), 32'd0);

`ifdef FMA_RESULT_FLAGS_EN
    single_op("flag_nan", 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000);
    check("flag_nan_flags", 32'(out_flags), 32'b1000);
    out_ready = 1'b1;
    tick();
    single_op("flag_zero", 32'h00000000, 32'h3F800000, 32'h80000000, 32'h00000000);
    check("flag_zero_flags", 32'(out_flags), 32'b0010);
    out_ready = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fma_issue_buffer.md
Name: fma_issue_buffer

Overview:
- Upstream and downstream wrapper for the combinational FP32 fused multiply-add core `Top` (D = A*B + C).
- Buffers operand triples in a small FIFO and presents each triple to the core on registered operand lines.
- Holds the operands stable for a programmable settle window that covers the gate-level combinational delay, then captures D into a result register.
- Hands results downstream on a valid/ready handshake, so the block turns the unclocked FMA core into a flow-controlled pipeline stage.

Parameters:
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- SETTLE, 2, cycles operands are held at the core before D is sampled; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream operand triple valid.
- in_ready  out  1  FIFO can accept a triple; equals (count < DEPTH).
- in_a  in  32  FP32 multiplicand.
- in_b  in  32  FP32 multiplier.
- in_c  in  32  FP32 addend.
- fma_a  out  32  registered operand to core A.
- fma_b  out  32  registered operand to core B.
- fma_c  out  32  registered operand to core C.
- fma_d  in  32  core result D (combinational from fma_a/b/c).
- out_valid  out  1  out_d holds an unconsumed result.
- out_ready  in  1  downstream accepts result.
- out_d  out  32  captured FP32 result.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: FIFO emptied (count=0, pointers 0), state IDLE, settle counter 0, fma_a/b/c=0, out_d=0, out_valid=0. Reset mid-operation discards queued and in-flight triples; the result register is cleared with no partial output.
- Push: when in_valid && in_ready, the triple is written at the write pointer. Pointers wrap modulo DEPTH.
- No bypass: a triple pushed at edge k is poppable no earlier than edge k+1.
- When full, in_ready=0 and in_valid is ignored. The input interface does not require upstream to hold data while in_ready=0.
- FSM states:
  - IDLE: if count>0, pop the head into fma_a/b/c, load settle counter with SETTLE-1, go to SETTLE_WAIT.
  - SETTLE_WAIT: if counter==0, out_d<=fma_d, out_valid<=1, go to HOLD; else decrement.
  - HOLD: out_d and out_valid are stable. On out_valid && out_ready:
    - out_valid<=0.
    - If count>0 (including only entries present before this edge), pop the next triple at the same edge and go to SETTLE_WAIT.
    - Otherwise go to IDLE.
- Push and pop in the same cycle: count is unchanged. This is legal at any occupancy except full, where no push occurs.
- Operand hold: fma_a/b/c keep the last issued triple after capture and in IDLE. They change only on pop, so the core input never glitches between triples.
- Latency: a triple popped at edge k gives out_valid=1 after edge k+SETTLE.
- Empty-FIFO latency: a push at edge p gives out_valid after edge p+1+SETTLE.
- Throughput: with out_ready held high, one result per SETTLE+1 cycles.
- Back-pressure: out_ready low keeps HOLD indefinitely; the FIFO keeps filling up to DEPTH.
- count is the registered occupancy: +1 on push only, -1 on pop only.

Optional Feature:
- Macro: FMA_RESULT_FLAGS_EN.
- When defined, add output out_flags [3:0] = {is_nan, is_inf, is_zero, is_denorm}.
  - Decoded from fma_d and registered at the same edge as out_d.
  - Reset 0; stable while out_valid.
  - is_zero covers ±0. is_denorm means exponent 0 with mantissa ≠0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Single op, SETTLE=2: push A=3F800000, B=40000000, C=40400000 at edge 0 -> fma_a/b/c loaded at edge 1; out_valid=1, out_d=40A00000 after edge 3; cleared on out_ready.
- Back-to-back: push 4 triples with out_ready=1 -> results in push order, spaced exactly 3 cycles; count peaks then drains to 0; in_ready never deasserts.
- Full/back-pressure with DEPTH=4 and out_ready=0:
  - Push 6 triples -> first issued; count reaches 4 and in_ready=0; further pushes are ignored.
  - Raise out_ready -> 5 results total, with no loss or duplication among accepted triples.
- Simultaneous push/pop at count=2 -> count stays 2; FIFO pointer wrap verified past index 3.
- Reset mid-SETTLE_WAIT: assert rst for 1 cycle with count=3 -> out_valid=0, out_d=0, count=0, fma_*=0; the next push behaves like the single-op case.
- With FMA_RESULT_FLAGS_EN, SETTLE=2:
  - A=7F800000, B=00000000, C=3F800000 -> out_d is NaN, out_flags=1000.
  - A=00000000, B=3F800000, C=80000000 -> out_flags=0010.
